// File: rtl/seq_pkg.sv
// Shared encodings for the accumulator-machine sequencer and its datapath:
// opcodes, FSM states, AC source selects, ALU operations and instruction classes.
package seq_pkg;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_LOAD     = 4'h1;
    localparam logic [3:0] OP_STORE    = 4'h2;
    localparam logic [3:0] OP_ADD      = 4'h3;
    localparam logic [3:0] OP_SUBT     = 4'h4;
    localparam logic [3:0] OP_AND      = 4'h5;
    localparam logic [3:0] OP_OR       = 4'h6;
    localparam logic [3:0] OP_HALT     = 4'h7;
    localparam logic [3:0] OP_SKIPCOND = 4'h8;
    localparam logic [3:0] OP_JUMP     = 4'h9;
    localparam logic [3:0] OP_CLEAR    = 4'hA;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_DEC  = 4'd4,
        S_RD0  = 4'd5,
        S_RD1  = 4'd6,
        S_EX   = 4'd7,
        S_ST0  = 4'd8,
        S_ST1  = 4'd9,
        S_HALT = 4'd10
    } state_t;

    localparam logic [1:0] AC_SEL_ALU  = 2'd0;
    localparam logic [1:0] AC_SEL_MBR  = 2'd1;
    localparam logic [1:0] AC_SEL_ZERO = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;

    // Illegal opcodes are reported as CL_HALT with is_legal cleared.
    typedef enum logic [2:0] {
        CL_NOP   = 3'd0,
        CL_LOAD  = 3'd1,
        CL_ALU   = 3'd2,
        CL_STORE = 3'd3,
        CL_HALT  = 3'd4,
        CL_SKIP  = 3'd5,
        CL_JUMP  = 3'd6,
        CL_CLEAR = 3'd7
    } op_class_t;

    function automatic logic skip_taken(input logic [1:0] cond,
                                        input logic       neg,
                                        input logic       zero);
        logic taken;
        case (cond)
            2'b00:   taken = neg;
            2'b01:   taken = zero;
            2'b10:   taken = !neg && !zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder: opcode -> instruction class, ALU operation, legality.
// Zero latency; no flow control.
module seq_decode
    import seq_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        op_class,
    output logic [3:0]       alu_op,
    output logic             is_legal
);

    always_comb begin
        op_class = CL_HALT;
        alu_op   = ALU_ADD;
        is_legal = 1'b1;
        case (opcode)
            OPC_W'(OP_NOP):      op_class = CL_NOP;
            OPC_W'(OP_LOAD):     op_class = CL_LOAD;
            OPC_W'(OP_STORE):    op_class = CL_STORE;
            OPC_W'(OP_ADD):      begin op_class = CL_ALU; alu_op = ALU_ADD; end
            OPC_W'(OP_SUBT):     begin op_class = CL_ALU; alu_op = ALU_SUB; end
            OPC_W'(OP_AND):      begin op_class = CL_ALU; alu_op = ALU_AND; end
            OPC_W'(OP_OR):       begin op_class = CL_ALU; alu_op = ALU_OR;  end
            OPC_W'(OP_HALT):     op_class = CL_HALT;
            OPC_W'(OP_SKIPCOND): op_class = CL_SKIP;
            OPC_W'(OP_JUMP):     op_class = CL_JUMP;
            OPC_W'(OP_CLEAR):    op_class = CL_CLEAR;
            default: begin
                op_class = CL_HALT;
                is_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_execute_sequencer.sv
// Multi-cycle fetch/decode/operand/execute controller for the 16-bit accumulator machine.
// Control outputs decode combinationally from the current state; 4, 6 or 7 cycles per instruction.
module fetch_execute_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int OPC_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic [1:0]       ir_cond,
    input  logic             ac_neg,
    input  logic             ac_zero,
    output logic             mar_load,
    output logic             mar_sel,
    output logic             pc_load,
    output logic             pc_sel,
    output logic             mbr_load,
    output logic             mbr_sel,
    output logic             ir_load,
    output logic             ac_load,
    output logic [1:0]       ac_sel,
    output logic [3:0]       alu_op,
    output logic             mem_we,
    output logic             halted,
    output logic             illegal
);

    // The instruction word is exactly opcode plus operand address.
    if (ADDR_W + OPC_W != 16 || OPC_W != 4) begin : g_width_check
        $error("fetch_execute_sequencer: ADDR_W + OPC_W must be 16 with OPC_W = 4");
    end

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    op_class_t  dec_class;
    logic [3:0] dec_alu_op;
    logic       dec_legal;

    seq_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode   (ir_opcode),
        .op_class (dec_class),
        .alu_op   (dec_alu_op),
        .is_legal (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   state_d = S_DEC;
            S_DEC: begin
                case (dec_class)
                    CL_LOAD, CL_ALU: state_d = S_RD0;
                    CL_STORE:        state_d = S_ST0;
                    CL_HALT:         state_d = S_HALT;
                    default:         state_d = S_F0;
                endcase
                if (!dec_legal) illegal_d = 1'b1;
            end
            S_RD0:  state_d = S_RD1;
            S_RD1:  state_d = S_EX;
            S_EX:   state_d = S_F0;
            S_ST0:  state_d = S_ST1;
            S_ST1:  state_d = S_F0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset forces every control low immediately so a store caught in S_ST1 cannot write.
    always_comb begin
        mar_load = 1'b0;
        mar_sel  = 1'b0;
        pc_load  = 1'b0;
        pc_sel   = 1'b0;
        mbr_load = 1'b0;
        mbr_sel  = 1'b0;
        ir_load  = 1'b0;
        ac_load  = 1'b0;
        ac_sel   = AC_SEL_ALU;
        alu_op   = ALU_ADD;
        mem_we   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_F0: mar_load = 1'b1;
                S_F1: pc_load  = 1'b1;
                S_F2: ir_load  = 1'b1;
                S_DEC: begin
                    case (dec_class)
                        CL_LOAD, CL_ALU, CL_STORE: begin
                            mar_load = 1'b1;
                            mar_sel  = 1'b1;
                        end
                        CL_SKIP: pc_load = skip_taken(ir_cond, ac_neg, ac_zero);
                        CL_JUMP: begin
                            pc_load = 1'b1;
                            pc_sel  = 1'b1;
                        end
                        CL_CLEAR: begin
                            ac_load = 1'b1;
                            ac_sel  = AC_SEL_ZERO;
                        end
                        default: ;
                    endcase
                end
                S_RD1: mbr_load = 1'b1;
                S_EX: begin
                    ac_load = 1'b1;
                    if (dec_class == CL_LOAD) begin
                        ac_sel = AC_SEL_MBR;
                    end else begin
                        ac_sel = AC_SEL_ALU;
                        alu_op = dec_alu_op;
                    end
                end
                S_ST0: begin
                    mbr_load = 1'b1;
                    mbr_sel  = 1'b1;
                end
                S_ST1: mem_we = 1'b1;
                default: ;
            endcase
        end
    end

    assign halted  = (state_q == S_HALT) && !reset;
    assign illegal = illegal_q && !reset;

endmodule

// File: tb/tb_fetch_execute_sequencer.sv
// Sequencer bench: a small behavioural datapath and memory close the loop around the DUT;
// expected memory writes, ALU ops and halt events are queued and checked by a monitor.
module tb_fetch_execute_sequencer;
    import seq_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic run   = 1'b0;
    logic [3:0] ir_opcode;
    logic [1:0] ir_cond;
    logic ac_neg, ac_zero;
    logic mar_load, mar_sel, pc_load, pc_sel, mbr_load, mbr_sel, ir_load, ac_load;
    logic [1:0] ac_sel;
    logic [3:0] alu_op;
    logic mem_we, halted, illegal;

    always #5 clock = ~clock;

    fetch_execute_sequencer #(.ADDR_W(12), .OPC_W(4)) dut (
        .clock(clock), .reset(reset), .run(run),
        .ir_opcode(ir_opcode), .ir_cond(ir_cond), .ac_neg(ac_neg), .ac_zero(ac_zero),
        .mar_load(mar_load), .mar_sel(mar_sel), .pc_load(pc_load), .pc_sel(pc_sel),
        .mbr_load(mbr_load), .mbr_sel(mbr_sel), .ir_load(ir_load),
        .ac_load(ac_load), .ac_sel(ac_sel), .alu_op(alu_op),
        .mem_we(mem_we), .halted(halted), .illegal(illegal)
    );

    // Behavioural datapath and memory with a one-cycle registered read.
    logic [15:0] mem [0:4095];
    logic [15:0] ac, mbr, ir, dout;
    logic [11:0] mar, pc;
    logic        mem_clr = 1'b0;
    logic        ld_vld  = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [15:0] ld_dat  = '0;

    assign ir_opcode = ir[15:12];
    assign ir_cond   = ir[11:10];
    assign ac_neg    = ac[15];
    assign ac_zero   = (ac == 16'h0000);

    function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b1000: return a & b;
            4'b1001: return a | b;
            default: return 16'hDEAD;
        endcase
    endfunction

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
        end else if (ld_vld) begin
            mem[ld_addr] <= ld_dat;
        end else if (mem_we) begin
            mem[mar] <= mbr;
        end
        if (reset) begin
            ac <= '0; mbr <= '0; ir <= '0; dout <= '0; mar <= '0; pc <= '0;
        end else begin
            dout <= mem[mar];
            if (mar_load) mar <= mar_sel ? ir[11:0] : pc;
            if (pc_load)  pc  <= pc_sel ? ir[11:0] : pc + 12'd1;
            if (mbr_load) mbr <= mbr_sel ? ac : dout;
            if (ir_load)  ir  <= dout;
            if (ac_load) begin
                case (ac_sel)
                    2'd0:    ac <= alu(alu_op, ac, mbr);
                    2'd1:    ac <= mbr;
                    default: ac <= 16'h0000;
                endcase
            end
        end
    end

    int cyc = 0;
    int base = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard
    typedef struct { logic [11:0] addr; logic [15:0] dat; } wr_t;
    typedef struct { int cycles; logic ill; logic [11:0] pc; logic [11:0] mar; } hl_t;
    wr_t        wq[$];
    hl_t        hq[$];
    logic [3:0] aq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    logic halted_seen = 1'b0;
    always @(negedge clock) begin
        if (mem_we) begin
            chk("we_vs_mbr_load", {31'd0, mbr_load}, 32'd0);
            if (wq.size() == 0) fail_now("unexpected_mem_we");
            else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_addr", {20'd0, mar}, {20'd0, w.addr});
                chk("wr_data", {16'd0, mbr}, {16'd0, w.dat});
            end
        end
        if (!reset && ac_load && ac_sel == 2'd0) begin
            if (aq.size() == 0) fail_now("unexpected_alu_op");
            else chk("alu_op", {28'd0, alu_op}, {28'd0, aq.pop_front()});
        end
        if (reset) halted_seen = 1'b0;
        else if (halted && !halted_seen) begin
            halted_seen = 1'b1;
            if (hq.size() == 0) fail_now("unexpected_halt");
            else begin
                hl_t h;
                h = hq.pop_front();
                chk("halt_cycles", cyc - base, h.cycles);
                chk("halt_illegal", {31'd0, illegal}, {31'd0, h.ill});
                chk("halt_pc", {20'd0, pc}, {20'd0, h.pc});
                chk("halt_mar", {20'd0, mar}, {20'd0, h.mar});
            end
        end
    end

    task automatic ld(input logic [11:0] a, input logic [15:0] d);
        ld_vld = 1'b1; ld_addr = a; ld_dat = d;
        @(posedge clock); #1;
        ld_vld = 1'b0;
    endtask

    task automatic start_reset();
        reset = 1'b1; run = 1'b0; mem_clr = 1'b1;
        @(posedge clock); #1;
        mem_clr = 1'b0;
    endtask

    task automatic end_reset();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // run high for one cycle; optionally pulse it again while the DUT is in S_F1.
    task automatic run_prog(input logic pulse_f1);
        run = 1'b1; base = cyc;
        @(posedge clock); #1; run = 1'b0;
        @(posedge clock); #1; run = pulse_f1;
        @(posedge clock); #1; run = 1'b0;
    endtask

    task automatic wait_halt(input string nm, input int budget);
        int n = 0;
        while (!halted && n < budget) begin @(negedge clock); n++; end
        if (!halted) fail_now({nm, "_halt_timeout"});
        repeat (2) @(negedge clock);
    endtask

    task automatic add_halt(input int c, input logic il, input logic [11:0] p, input logic [11:0] m);
        hl_t h;
        h.cycles = c; h.ill = il; h.pc = p; h.mar = m;
        hq.push_back(h);
    endtask

    task automatic add_wr(input logic [11:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a; w.dat = d;
        wq.push_back(w);
    endtask

    initial begin
        // Reset state
        start_reset();
        end_reset();
        @(negedge clock);
        chk("rst_outputs", {20'd0, mar_load, mar_sel, pc_load, pc_sel, mbr_load, mbr_sel,
                            ir_load, ac_load, ac_sel, mem_we, halted}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        repeat (3) @(negedge clock);
        chk("idle_hold", 32'(dut.state_q), 32'(S_IDLE));

        // 1: LOAD 4, ADD 5, STORE 6, HALT
        start_reset();
        ld(12'h000, 16'h1004); ld(12'h001, 16'h3005); ld(12'h002, 16'h2006); ld(12'h003, 16'h7000);
        ld(12'h004, 16'h0003); ld(12'h005, 16'h0004);
        end_reset();
        aq.push_back(ALU_ADD);
        add_wr(12'h006, 16'h0007);
        add_halt(25, 1'b0, 12'h004, 12'h003);
        run_prog(1'b0);
        wait_halt("t1", 60);
        chk("t1_mem6", {16'd0, mem[6]}, 32'h0007);

        // 2: CLEAR, SKIPCOND zero skips HALT, JUMP 0x010 lands on a HALT
        start_reset();
        ld(12'h000, 16'hA000); ld(12'h001, 16'h8400); ld(12'h002, 16'h7000); ld(12'h003, 16'h9010);
        ld(12'h010, 16'h7000);
        end_reset();
        add_halt(17, 1'b0, 12'h011, 12'h010);
        run_prog(1'b0);
        wait_halt("t2", 60);

        // 3: undefined opcode, then 5a: run held high while halted
        start_reset();
        ld(12'h000, 16'hB000);
        end_reset();
        add_halt(5, 1'b1, 12'h001, 12'h000);
        run_prog(1'b0);
        wait_halt("t3", 30);
        run = 1'b1;
        repeat (5) @(negedge clock);
        chk("t5_halt_state", 32'(dut.state_q), 32'(S_HALT));
        chk("t5_halted", {31'd0, halted}, 32'd1);
        chk("t5_illegal_sticky", {31'd0, illegal}, 32'd1);
        chk("t5_pc", {20'd0, pc}, 32'h001);
        run = 1'b0;

        // 4: reset lands during S_ST0 of a STORE
        start_reset();
        ld(12'h000, 16'h2006); ld(12'h006, 16'h1234);
        end_reset();
        chk("t4_illegal_cleared", {31'd0, illegal}, 32'd0);
        run_prog(1'b0);
        begin
            int n = 0;
            while (!(mbr_load && mbr_sel) && n < 20) begin @(negedge clock); n++; end
            if (!(mbr_load && mbr_sel)) fail_now("t4_st0_timeout");
        end
        reset = 1'b1;
        #1 chk("t4_we_in_reset", {31'd0, mem_we}, 32'd0);
        @(posedge clock); #1;
        chk("t4_state_idle", 32'(dut.state_q), 32'(S_IDLE));
        reset = 1'b0;
        @(negedge clock);
        chk("t4_we_after", {31'd0, mem_we}, 32'd0);
        chk("t4_state_idle2", 32'(dut.state_q), 32'(S_IDLE));
        repeat (4) @(negedge clock);
        chk("t4_target", {16'd0, mem[6]}, 32'h1234);

        // 6 (+5b): LOAD 8 (=2), SUBT 5 (=3) -> 0xFFFF, SKIPCOND neg skips HALT, STORE 9, NOP, HALT
        start_reset();
        ld(12'h000, 16'h1008); ld(12'h001, 16'h4005); ld(12'h002, 16'h8000); ld(12'h003, 16'h7000);
        ld(12'h004, 16'h2009); ld(12'h005, 16'h0003); ld(12'h006, 16'h7000); ld(12'h008, 16'h0002);
        end_reset();
        aq.push_back(ALU_SUB);
        add_wr(12'h009, 16'hFFFF);
        add_halt(33, 1'b0, 12'h007, 12'h006);
        run_prog(1'b1);
        wait_halt("t6", 80);
        chk("t6_ac", {16'd0, ac}, 32'hFFFF);
        chk("t6_mem9", {16'd0, mem[9]}, 32'hFFFF);

        chk("wq_drained", wq.size(), 32'd0);
        chk("hq_drained", hq.size(), 32'd0);
        chk("aq_drained", aq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
